// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR stream decryptor: FSM states,
// the candidate tap table and the keystream next-state rule.
package lfsr_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_SEED,
        CHECK,
        NEXT_TAP,
        DEC,
        EMIT,
        DONE
    } state_t;

    localparam logic [7:0] DEFAULT_PRE_CHAR = 8'h5F;
    localparam int         NUM_TAPS         = 8;

    // Candidates are tried in this order; the first one that reproduces the preamble wins.
    localparam logic [7:0] TAP_TABLE [NUM_TAPS] = '{
        8'hE1, 8'hD4, 8'hC6, 8'hB8, 8'hB4, 8'hB2, 8'hFA, 8'hF3
    };

    function automatic logic [7:0] lfsr_step(input logic [7:0] s, input logic [7:0] tap);
        return {s[6:0], ^(s & tap)};
    endfunction

endpackage

// File: rtl/lfsr_stream_decrypt_if.sv
// Ciphertext memory read port plus plaintext valid/ready stream of the decryptor.
interface lfsr_stream_decrypt_if #(
    parameter int ADDR_W = 8
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              out_valid;
    logic [7:0]        out_data;
    logic              out_ready;

    modport master (
        output rd_en, rd_addr, out_valid, out_data,
        input  rd_data, out_ready
    );

    modport slave (
        input  rd_en, rd_addr, out_valid, out_data,
        output rd_data, out_ready
    );
endinterface

// File: rtl/lfsr_keystream.sv
// 8-bit Fibonacci-style keystream register: load a seed, or shift left with
// the parity of (state & tap) entering at bit 0.
module lfsr_keystream
    import lfsr_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       en,
    input  logic [7:0] seed,
    input  logic [7:0] tap,
    output logic [7:0] state
);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= '0;
        end else if (load) begin
            state <= seed;
        end else if (en) begin
            state <= lfsr_step(state, tap);
        end
    end

endmodule

// File: rtl/lfsr_stream_decrypt.sv
// Recovers seed and tap of an LFSR-encrypted message from its known preamble,
// then streams the decrypted payload. Each read takes an issue and a capture cycle.
module lfsr_stream_decrypt
    import lfsr_pkg::*;
#(
    parameter int         PRE_LEN  = 6,
    parameter logic [7:0] PRE_CHAR = DEFAULT_PRE_CHAR,
    parameter int         ADDR_W   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     msg_len,
    lfsr_stream_decrypt_if.master bus,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [7:0]            found_tap,
    output logic [7:0]            found_seed
);

    localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PRE_LEN_A = ADDR_W'(PRE_LEN);
    localparam logic [ADDR_W-1:0] LAST_PRE  = ADDR_W'(PRE_LEN - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] len_q, len_d, k_q, k_d;
    logic [2:0]        t_q, t_d;
    logic [7:0]        seed_q, seed_d;
    logic              wait_q, wait_d;
    logic              out_valid_q, out_valid_d;
    logic [7:0]        out_data_q, out_data_d;
    logic              error_d;
    logic [7:0]        found_tap_d, found_seed_d;

    logic              rd_en_c;
    logic [ADDR_W-1:0] rd_addr_c;
    logic              ks_load, ks_en;
    logic [7:0]        ks_seed, ks_state;
    logic [7:0]        rx_seed;
    logic              pre_match;

    // The keystream is stepped in the read-issue cycle, so in the capture cycle it already holds state_k.
    lfsr_keystream u_keystream (
        .clk   (clk),
        .reset (reset),
        .load  (ks_load),
        .en    (ks_en),
        .seed  (ks_seed),
        .tap   (TAP_TABLE[t_q]),
        .state (ks_state)
    );

    assign rx_seed   = bus.rd_data ^ PRE_CHAR;
    assign pre_match = (bus.rd_data ^ ks_state) == PRE_CHAR;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            len_q       <= '0;
            k_q         <= '0;
            t_q         <= '0;
            seed_q      <= '0;
            wait_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            error       <= 1'b0;
            found_tap   <= '0;
            found_seed  <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            k_q         <= k_d;
            t_q         <= t_d;
            seed_q      <= seed_d;
            wait_q      <= wait_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            error       <= error_d;
            found_tap   <= found_tap_d;
            found_seed  <= found_seed_d;
        end
    end

    // NOTE: every signal driven here gets a default first so no latch can be inferred.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        k_d          = k_q;
        t_d          = t_q;
        seed_d       = seed_q;
        wait_d       = 1'b0;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        error_d      = error;
        found_tap_d  = found_tap;
        found_seed_d = found_seed;
        rd_en_c      = 1'b0;
        rd_addr_c    = '0;
        ks_load      = 1'b0;
        ks_en        = 1'b0;
        ks_seed      = seed_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    len_d        = msg_len;
                    error_d      = 1'b0;
                    found_tap_d  = '0;
                    found_seed_d = '0;
                    if (msg_len < PRE_LEN_A) begin
                        error_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = RD_SEED;
                    end
                end
            end
            RD_SEED: begin
                if (!wait_q) begin
                    rd_en_c = 1'b1;
                    wait_d  = 1'b1;
                end else begin
                    seed_d  = rx_seed;
                    ks_seed = rx_seed;
                    ks_load = 1'b1;
                    t_d     = '0;
                    k_d     = ONE_A;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (!wait_q) begin
                    rd_en_c   = 1'b1;
                    rd_addr_c = k_q;
                    ks_en     = 1'b1;
                    wait_d    = 1'b1;
                end else if (!pre_match) begin
                    state_d = NEXT_TAP;
                end else if (k_q == LAST_PRE) begin
                    found_tap_d  = TAP_TABLE[t_q];
                    found_seed_d = seed_q;
                    k_d          = PRE_LEN_A;
                    state_d      = (len_q == PRE_LEN_A) ? DONE : DEC;
                end else begin
                    k_d = k_q + ONE_A;
                end
            end
            NEXT_TAP: begin
                if (t_q == 3'd7) begin
                    error_d = 1'b1;
                    state_d = DONE;
                end else begin
                    t_d     = t_q + 3'd1;
                    ks_load = 1'b1;
                    k_d     = ONE_A;
                    state_d = CHECK;
                end
            end
            DEC: begin
                if (!wait_q) begin
                    rd_en_c   = 1'b1;
                    rd_addr_c = k_q;
                    ks_en     = 1'b1;
                    wait_d    = 1'b1;
                end else begin
                    out_data_d  = bus.rd_data ^ ks_state;
                    out_valid_d = 1'b1;
                    state_d     = EMIT;
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (k_q == len_q - ONE_A) begin
                        state_d = DONE;
                    end else begin
                        k_d     = k_q + ONE_A;
                        state_d = DEC;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy          = (state_q != IDLE) && (state_q != DONE);
    assign done          = (state_q == DONE);
    assign bus.rd_en     = rd_en_c;
    assign bus.rd_addr   = rd_addr_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_lfsr_stream_decrypt.sv
// Self-checking bench: directed cases plus randomized messages compared
// against a behavioural decryption model working on the memory image.
module tb_lfsr_stream_decrypt;

    localparam int         PRE_LEN  = 6;
    localparam logic [7:0] PRE_CHAR = 8'h5F;
    localparam int         MAX_CYC  = 2000;
    localparam logic [7:0] TAPS [8] = '{8'hE1, 8'hD4, 8'hC6, 8'hB8, 8'hB4, 8'hB2, 8'hFA, 8'hF3};

    logic       clk = 1'b0;
    logic       reset, start;
    logic [7:0] msg_len;
    logic       busy, done, error;
    logic [7:0] found_tap, found_seed;

    lfsr_stream_decrypt_if #(.ADDR_W(8)) bus ();

    lfsr_stream_decrypt #(.PRE_LEN(PRE_LEN), .PRE_CHAR(PRE_CHAR), .ADDR_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .msg_len    (msg_len),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .found_tap  (found_tap),
        .found_seed (found_seed)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

    int checks = 0, failures = 0;
    logic [7:0] got[$], exp_q[$];
    logic       exp_err;
    logic [7:0] exp_tap, exp_seed;
    int         exp_reads, rd_count, stall_seen;
    logic       valid_seen, inject_busy;

    function automatic logic [7:0] step(input logic [7:0] s, input logic [7:0] tap);
        int fb = $countones(s & tap) % 2;
        return 8'((int'(s) * 2) % 256 + fb);
    endfunction

    // Behavioural reference: brute-force the tap table against the preamble in memory.
    task automatic compute_expected(input logic [7:0] len);
        logic [7:0] s0, st;
        bit ok;
        exp_q.delete(); exp_err = 1'b1; exp_tap = '0; exp_seed = '0; exp_reads = 0;
        if (int'(len) < PRE_LEN) return;
        exp_reads = 1;
        s0 = mem[0] ^ PRE_CHAR;
        for (int ti = 0; ti < 8; ti++) begin
            st = s0; ok = 1'b1;
            for (int k = 1; k < PRE_LEN && ok; k++) begin
                st = step(st, TAPS[ti]);
                exp_reads++;
                if ((mem[k] ^ st) !== PRE_CHAR) ok = 1'b0;
            end
            if (ok) begin
                exp_err = 1'b0; exp_tap = TAPS[ti]; exp_seed = s0;
                for (int k = PRE_LEN; k < int'(len); k++) begin
                    st = step(st, TAPS[ti]);
                    exp_q.push_back(mem[k] ^ st);
                    exp_reads++;
                end
                return;
            end
        end
    endtask

    task automatic set_case1();
        logic [7:0] c1 [8] = '{8'h5E, 8'h5D, 8'h5B, 8'h57, 8'h4E, 8'h7C, 8'h0F, 8'hE7};
        foreach (c1[i]) mem[i] = c1[i];
    endtask

    // Starts one message and services the stream until done; protocol checks run every cycle.
    task automatic run_decrypt(input logic [7:0] len, input int stall, input bit rand_ready, input int inject_at);
        int cyc = 0, stall_left = stall;
        logic prev_wait = 1'b0;
        logic [7:0] prev_data = '0;
        got.delete(); rd_count = 0; stall_seen = 0; valid_seen = 1'b0; inject_busy = 1'b0;
        @(negedge clk); start = 1'b1; msg_len = len;
        @(negedge clk); start = 1'b0;
        while (!done && cyc < MAX_CYC) begin
            if (stall_left > 0 && bus.out_valid) begin
                bus.out_ready = 1'b0; stall_left--; stall_seen++;
            end else begin
                bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (cyc == inject_at) begin
                start = 1'b1; msg_len = 8'd3; inject_busy = busy;
            end else begin
                start = 1'b0; msg_len = len;
            end
            if (bus.rd_en) begin
                rd_count++; checks++;
                if (bus.rd_addr >= len) begin
                    failures++; $display("FAIL rd_addr_range: rd_addr=%0d msg_len=%0d", bus.rd_addr, len);
                end
            end
            if (prev_wait) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data) begin
                    failures++;
                    $display("FAIL hold: valid=%b data=%h, required valid=1 data=%h", bus.out_valid, bus.out_data, prev_data);
                end
            end
            if (bus.out_valid) begin
                valid_seen = 1'b1; checks++;
                if (bus.rd_en !== 1'b0) begin
                    failures++; $display("FAIL read_while_waiting: rd_en=%b required 0", bus.rd_en);
                end
            end
            if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
            prev_wait = bus.out_valid && !bus.out_ready;
            prev_data = bus.out_data;
            @(negedge clk); cyc++;
        end
        start = 1'b0;
        checks++;
        if (cyc >= MAX_CYC) begin
            failures++; $display("FAIL timeout: done never rose within %0d cycles", MAX_CYC);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; msg_len = '0; bus.out_ready = 1'b0;
        #2 reset = 1'b1;
        #1 checks++;
        if ({bus.rd_en, bus.rd_addr, bus.out_valid, bus.out_data, busy, done, error, found_tap, found_seed} !== '0) begin
            failures++; $display("FAIL reset_outputs: rd_en=%b rd_addr=%h out_valid=%b out_data=%h busy=%b done=%b error=%b tap=%h seed=%h, required all 0",
                                 bus.rd_en, bus.rd_addr, bus.out_valid, bus.out_data, busy, done, error, found_tap, found_seed);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk); checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL idle_after_reset: busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic check_case1(input string name);
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL %s_status: done=%b error=%b busy=%b required 1 0 0", name, done, error, busy);
        end
        checks++;
        if (found_tap !== 8'hB8 || found_seed !== 8'h01) begin
            failures++; $display("FAIL %s_key: tap=%h seed=%h required b8 01", name, found_tap, found_seed);
        end
        checks++;
        if (got.size() != 2 || got[0] !== 8'h48 || got[1] !== 8'h69) begin
            failures++; $display("FAIL %s_bytes: got %p required '{48,69}", name, got);
        end
        compute_expected(8'd8);
        checks++;
        if (rd_count != exp_reads) begin
            failures++; $display("FAIL %s_reads: %0d reads required %0d", name, rd_count, exp_reads);
        end
    endtask

    task automatic test_happy();
        set_case1();
        run_decrypt(8'd8, 0, 1'b0, -1);
        check_case1("happy");
    endtask

    task automatic test_backpressure();
        set_case1();
        run_decrypt(8'd8, 5, 1'b0, -1);
        checks++;
        if (stall_seen != 5) begin
            failures++; $display("FAIL bp_stall_cycles: stalled %0d cycles required 5", stall_seen);
        end
        check_case1("backpressure");
    endtask

    task automatic test_no_tap();
        mem[0] = 8'h5E;
        for (int i = 1; i < 6; i++) mem[i] = 8'h00;
        run_decrypt(8'd6, 0, 1'b0, -1);
        compute_expected(8'd6);
        checks++;
        if (done !== 1'b1 || error !== 1'b1) begin
            failures++; $display("FAIL no_tap_status: done=%b error=%b required 1 1", done, error);
        end
        checks++;
        if (valid_seen !== 1'b0 || rd_count != exp_reads) begin
            failures++; $display("FAIL no_tap_activity: valid_seen=%b reads=%0d required 0 %0d", valid_seen, rd_count, exp_reads);
        end
    endtask

    task automatic test_short();
        set_case1();
        run_decrypt(8'd3, 0, 1'b0, -1);
        checks++;
        if (done !== 1'b1 || error !== 1'b1 || rd_count != 0) begin
            failures++; $display("FAIL short_len3: done=%b error=%b reads=%0d required 1 1 0", done, error, rd_count);
        end
        run_decrypt(8'd6, 0, 1'b0, -1);
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || got.size() != 0 || valid_seen !== 1'b0) begin
            failures++; $display("FAIL preamble_only: done=%b error=%b bytes=%0d required 1 0 0", done, error, got.size());
        end
        checks++;
        if (found_tap !== 8'hB8 || found_seed !== 8'h01) begin
            failures++; $display("FAIL preamble_only_key: tap=%h seed=%h required b8 01", found_tap, found_seed);
        end
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        set_case1();
        bus.out_ready = 1'b0;
        @(negedge clk); start = 1'b1; msg_len = 8'd8;
        @(negedge clk); start = 1'b0;
        while (!bus.out_valid && cyc < MAX_CYC) begin
            @(negedge clk); cyc++;
        end
        checks++;
        if (cyc >= MAX_CYC) begin
            failures++; $display("FAIL reset_mid_timeout: out_valid never rose");
        end
        reset = 1'b1;
        #1 checks++;
        if ({bus.rd_en, bus.rd_addr, bus.out_valid, bus.out_data, busy, done, error, found_tap, found_seed} !== '0) begin
            failures++; $display("FAIL reset_mid_outputs: out_valid=%b out_data=%h busy=%b tap=%h seed=%h, required all 0",
                                 bus.out_valid, bus.out_data, busy, found_tap, found_seed);
        end
        @(negedge clk); reset = 1'b0;
        run_decrypt(8'd8, 0, 1'b0, -1);
        check_case1("after_reset");
    endtask

    task automatic test_start_busy();
        set_case1();
        run_decrypt(8'd8, 0, 1'b0, 3);
        checks++;
        if (inject_busy !== 1'b1) begin
            failures++; $display("FAIL inject_busy: busy=%b at injected start required 1", inject_busy);
        end
        check_case1("start_busy");
    endtask

    task automatic test_random();
        logic [7:0] seed, tap, st, len;
        for (int it = 0; it < 25; it++) begin
            seed = 8'($urandom_range(0, 255));
            tap  = TAPS[$urandom_range(0, 7)];
            len  = 8'($urandom_range(PRE_LEN, 40));
            st   = seed;
            for (int k = 0; k < int'(len); k++) begin
                mem[k] = ((k < PRE_LEN) ? PRE_CHAR : 8'($urandom_range(0, 255))) ^ st;
                st = step(st, tap);
            end
            if ($urandom_range(0, 3) == 0) mem[$urandom_range(1, 5)] ^= 8'($urandom_range(1, 255));
            compute_expected(len);
            run_decrypt(len, 0, 1'b1, -1);
            checks++;
            if (done !== 1'b1 || error !== exp_err) begin
                failures++; $display("FAIL rand%0d_status: done=%b error=%b required 1 %b", it, done, error, exp_err);
            end
            if (!exp_err) begin
                checks++;
                if (found_tap !== exp_tap || found_seed !== exp_seed) begin
                    failures++; $display("FAIL rand%0d_key: tap=%h seed=%h required %h %h", it, found_tap, found_seed, exp_tap, exp_seed);
                end
            end
            checks++;
            if (got != exp_q) begin
                failures++; $display("FAIL rand%0d_bytes: got %0d bytes required %0d (first got %h required %h)", it,
                                     got.size(), exp_q.size(), (got.size() > 0) ? got[0] : 8'h00, (exp_q.size() > 0) ? exp_q[0] : 8'h00);
            end
            checks++;
            if (rd_count != exp_reads) begin
                failures++; $display("FAIL rand%0d_reads: %0d reads required %0d", it, rd_count, exp_reads);
            end
        end
    endtask

    initial begin
        test_reset();
        test_happy();
        test_backpressure();
        test_no_tap();
        test_short();
        test_reset_mid();
        test_start_busy();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lfsr_stream_decrypt.md
Name: lfsr_stream_decrypt

Overview:
Receive-side counterpart of the 8-bit LFSR keystream encryptor. It reads an encrypted message from byte memory, recovers the seed and the tap pattern, then emits the decrypted payload bytes on a valid/ready stream.
- The seed comes from the first ciphertext byte and the known preamble character.
- The tap pattern is found by trying a fixed candidate table against the known preamble.

Parameters:
PRE_LEN, 6, number of leading plaintext bytes equal to PRE_CHAR (must be ≥2)
PRE_CHAR, 8'h5F, known preamble plaintext byte
ADDR_W, 8, memory address width; msg_len ≤ 2^ADDR_W-1

Ports:
clk  in  1  clock; all logic on posedge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; accepted only when busy=0
msg_len  in  ADDR_W  total message bytes incl. preamble; sampled when start is accepted
rd_en  out  1  memory read strobe
rd_addr  out  ADDR_W  memory read address
rd_data  in  8  ciphertext byte; valid exactly 1 cycle after rd_en/rd_addr
out_valid  out  1  plaintext byte valid
out_data  out  8  plaintext byte
out_ready  in  1  sink accepts the byte when out_valid&out_ready
busy  out  1  high from accepted start until done
done  out  1  level; high in DONE until the next accepted start
error  out  1  valid while done=1; 1 = no tap matched or msg_len<PRE_LEN
found_tap  out  8  recovered tap mask; valid when done=1 and error=0
found_seed  out  8  recovered initial state; valid when done=1 and error=0

Behaviour:
- Cipher model: state_0 = seed; state_{k+1} = {state_k[6:0], ^(state_k & tap)}; c_k = p_k ^ state_k; byte k is stored at address k.
- Reset (asynchronous): FSM goes to IDLE. All outputs are 0: rd_en, rd_addr, out_valid, out_data, busy, done, error, found_tap, found_seed.
- FSM states: IDLE, RD_SEED, CHECK, NEXT_TAP, DEC, EMIT, DONE.
- IDLE: on start, latch msg_len and set busy=1.
  - If msg_len<PRE_LEN: go to DONE with error=1; no reads issued, no output.
  - Otherwise go to RD_SEED.
- RD_SEED:
  - Read address 0.
  - Next cycle: seed = rd_data ^ PRE_CHAR; tap index t=0; k=1.
- CHECK:
  - Step the LFSR with TAP_TABLE[t]; read address k.
  - Compare rd_data ^ state_k against PRE_CHAR.
  - Mismatch: go to NEXT_TAP.
  - Match with k=PRE_LEN-1: tap found, go to DEC.
  - Match otherwise: k++ and stay in CHECK.
  - Reads may be pipelined (one per cycle) or issued one per 2 cycles; only ordering and results are checked.
- NEXT_TAP:
  - t++, reload state=seed, k=1, go to CHECK.
  - If t was 7: go to DONE with error=1.
- Tap selection: the first matching tap in table order wins.
- Seed 0 case: any tap matches, so index 0 is chosen. This is accepted behaviour, not an error.
- DEC/EMIT:
  - For k=PRE_LEN..msg_len-1: read c_k, step the state, present out_data = c_k ^ state_k.
  - out_valid is held and out_data is stable until out_ready.
  - No new read is issued while a byte is waiting.
  - After the last handshake, go to DONE with error=0.
  - If msg_len==PRE_LEN: go straight to DONE with error=0 and zero output bytes.
- DONE:
  - busy=0, done=1; found_tap/found_seed held.
  - start is accepted here (same behaviour as IDLE) and clears done/error in the cycle after.
- start while busy=1: ignored, with no effect on state or outputs.
- Reset mid-operation: immediate abort to reset values. Any pending out_valid is dropped.
- rd_addr is never driven ≥ the latched msg_len while rd_en=1.

Decomposition:
- Package lfsr_pkg holds:
  - the state enum
  - TAP_TABLE[8] = {8'hE1, 8'hD4, 8'hC6, 8'hB8, 8'hB4, 8'hB2, 8'hFA, 8'hF3}
  - the default PRE_CHAR constant
- One sub-module, lfsr_keystream: 8-bit register with init (load) / en (step) / tap inputs, using the next-state rule above.
- The decryptor instantiates lfsr_keystream and reloads it with seed on each new tap trial.

Test Plan:
1. Happy path, seed 0x01, tap 0xB8, plaintext "______Hi", msg_len=8, out_ready=1.
   - Memory = 5E 5D 5B 57 4E 7C 0F E7.
   - Required: out bytes 0x48, 0x69; done=1, error=0, found_tap=0xB8, found_seed=0x01.
2. Backpressure, same memory as 1.
   - out_ready low for 5 cycles while out_valid=1.
   - Required: out_data stays 0x48 with out_valid high and no extra rd_en; 0x69 follows after ready.
3. No tap matches: memory 5E 00 00 00 00 00, msg_len=6.
   - Required: done=1, error=1, out_valid never asserted.
4. Short message: msg_len=3.
   - Required: done=1, error=1 with no rd_en ever asserted.
   - Second case: msg_len=6 with the case 1 preamble; required done=1, error=0, zero output bytes.
5. Reset mid-decrypt: assert reset while out_valid=1 during case 1.
   - Required: all outputs 0 immediately.
   - A fresh start then reproduces case 1 results exactly.
6. Start while busy: pulse start with msg_len=3 during the case 1 CHECK phase.
   - Required: ignored; case 1 results are unchanged.
